// File: rtl/la_readout_pkg.sv
// Shared types and constants for the logic analyzer readout sequencer.
package la_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_EMIT  = 3'd4
  } rd_state_e;

  localparam logic [3:0]  LA_STATE_CAPTURED = 4'd4;
  localparam int unsigned WORD_WIDTH        = 16;
  localparam int unsigned BRAM_READ_LATENCY = 2;

  function automatic int unsigned words_for(input int unsigned width);
    return (width + WORD_WIDTH - 1) / WORD_WIDTH;
  endfunction

endpackage

// File: rtl/la_word_serializer.sv
// Splits one BRAM sample into WORD_WIDTH-bit stream words, LSW first,
// and flags completion of the word group on its final handshake.
module la_word_serializer
  import la_readout_pkg::*;
#(
  parameter  int unsigned SAMPLE_WIDTH = 32,
  localparam int unsigned WORDS        = words_for(SAMPLE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    emit,
  input  logic [SAMPLE_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    word_last,
  output logic                    group_done
);

  localparam int unsigned SHW  = WORDS * WORD_WIDTH;
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [SHW-1:0]  shreg;
  logic [IDXW-1:0] word_idx;
  logic            hs;

  assign out_valid  = emit;
  assign out_data   = shreg[WORD_WIDTH-1:0];
  assign hs         = emit & out_ready;
  assign word_last  = (word_idx == IDXW'(WORDS - 1));
  assign group_done = hs & word_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      word_idx <= '0;
    end else if (load) begin
      shreg    <= SHW'(rdata);
      word_idx <= '0;
    end else if (hs) begin
      shreg    <= shreg >> WORD_WIDTH;
      word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: rtl/logic_analyzer_readout_sequencer.sv
// Reads all captured samples out of the sample BRAM oldest-first and streams them
// as 16-bit words. Optional stall timeout: define LA_READOUT_TIMEOUT_EN.
module logic_analyzer_readout_sequencer
  import la_readout_pkg::*;
#(
  parameter  int unsigned SAMPLE_DEPTH   = 4096,
  parameter  int unsigned SAMPLE_WIDTH   = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned ADDR_WIDTH     = $clog2(SAMPLE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              la_state,
  input  logic [ADDR_WIDTH-1:0]   start_ptr,
  input  logic                    start,
  input  logic                    abort,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_rd_en,
  input  logic [SAMPLE_WIDTH-1:0] bram_rdata,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(SAMPLE_DEPTH);

  rd_state_e             state;
  logic                  start_low_q;
  logic                  start_edge;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] sample_idx;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic                  load;
  logic                  emit;
  logic                  word_last;
  logic                  group_done;
  logic                  last_sample;
  logic                  timeout_hit;

  // Register holds "start was low last cycle" so a start held high through
  // reset release never looks like a rising edge.
  assign start_edge = start & start_low_q;

  assign load        = (state == ST_LOAD);
  assign emit        = (state == ST_EMIT);
  assign bram_rd_en  = (state == ST_FETCH);
  assign busy        = (state != ST_IDLE);
  assign last_sample = (sample_idx == ADDR_WIDTH'(SAMPLE_DEPTH - 1));
  assign out_last    = emit & word_last & last_sample;

  // Compare-subtract wrap keeps non-power-of-2 depths correct.
  always_comb begin
    addr_sum = {1'b0, base} + {1'b0, sample_idx};
    if (addr_sum >= DEPTH_EXT) addr_sum = addr_sum - DEPTH_EXT;
    bram_addr = addr_sum[ADDR_WIDTH-1:0];
  end

`ifdef LA_READOUT_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stalled;

  assign stalled     = emit & ~out_ready;
  assign timeout_hit = stalled & (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stall_cnt <= '0;
    else if (!stalled || abort || timeout_hit) stall_cnt <= '0;
    else                                   stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_low_q <= 1'b0;
      base        <= '0;
      sample_idx  <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      start_low_q <= ~start;
      done        <= 1'b0;
      error       <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_edge) begin
              if (la_state == LA_STATE_CAPTURED) begin
                base       <= start_ptr;
                sample_idx <= '0;
                state      <= ST_FETCH;
              end else begin
                error <= 1'b1;
              end
            end
          end
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT:  state <= ST_LOAD;
          ST_LOAD:  state <= ST_EMIT;
          ST_EMIT: begin
            if (timeout_hit) begin
              state <= ST_IDLE;
              error <= 1'b1;
            end else if (group_done) begin
              if (last_sample) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                sample_idx <= sample_idx + 1'b1;
                state      <= ST_FETCH;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  la_word_serializer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .emit      (emit),
    .rdata     (bram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_last (word_last),
    .group_done(group_done)
  );

endmodule

// File: tb/tb_logic_analyzer_readout_sequencer.sv
// Directed bench: DUT A (depth 8, 32-bit), DUT B (depth 6, 20-bit) with BRAM models.
module tb_logic_analyzer_readout_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A signals
  logic [3:0]  a_la = 4'd4;
  logic [2:0]  a_ptr = '0, a_addr;
  logic        a_start = 0, a_abort = 0, a_rd_en, a_valid, a_ready = 0, a_last, a_busy, a_done, a_error;
  logic [31:0] a_rdata = '0, a_p1 = '0;
  logic [15:0] a_data;
  logic [31:0] a_mem [8];

  // DUT B signals
  logic [3:0]  b_la = 4'd4;
  logic [2:0]  b_ptr = '0, b_addr;
  logic        b_start = 0, b_abort = 0, b_rd_en, b_valid, b_ready = 0, b_last, b_busy, b_done, b_error;
  logic [19:0] b_rdata = '0, b_p1 = '0;
  logic [15:0] b_data;
  logic [19:0] b_mem [6];

  logic_analyzer_readout_sequencer #(
    .SAMPLE_DEPTH(8), .SAMPLE_WIDTH(32), .TIMEOUT_CYCLES(10)
  ) u_a (
    .clk(clk), .rst(rst), .la_state(a_la), .start_ptr(a_ptr), .start(a_start), .abort(a_abort),
    .bram_addr(a_addr), .bram_rd_en(a_rd_en), .bram_rdata(a_rdata), .out_data(a_data),
    .out_valid(a_valid), .out_ready(a_ready), .out_last(a_last), .busy(a_busy),
    .done(a_done), .error(a_error)
  );

  logic_analyzer_readout_sequencer #(
    .SAMPLE_DEPTH(6), .SAMPLE_WIDTH(20), .TIMEOUT_CYCLES(10)
  ) u_b (
    .clk(clk), .rst(rst), .la_state(b_la), .start_ptr(b_ptr), .start(b_start), .abort(b_abort),
    .bram_addr(b_addr), .bram_rd_en(b_rd_en), .bram_rdata(b_rdata), .out_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last), .busy(b_busy),
    .done(b_done), .error(b_error)
  );

  // Two-cycle BRAM read models
  always @(posedge clk) begin
    if (a_rd_en) a_p1 <= a_mem[a_addr];
    a_rdata <= a_p1;
    if (b_rd_en) b_p1 <= b_mem[b_addr];
    b_rdata <= b_p1;
  end

  // Observation logs, sampled on the falling edge
  logic [15:0] a_words[$], b_words[$];
  logic [2:0]  a_addrs[$], b_addrs[$];
  int a_done_cnt, a_done_cyc, a_err_cnt, a_err_cyc, a_busy_cnt, a_first_valid, a_last_pos, a_last_cnt, a_last_cyc;
  int b_done_cnt, b_done_cyc, b_last_pos, b_last_cnt, b_last_cyc, b_err_cnt, b_busy_cnt;

  always @(negedge clk) begin
    if (a_rd_en) a_addrs.push_back(a_addr);
    if (a_valid && a_first_valid < 0) a_first_valid = cyc;
    if (a_valid && a_ready) begin
      a_words.push_back(a_data);
      if (a_last) begin a_last_cnt++; a_last_pos = a_words.size(); a_last_cyc = cyc; end
    end
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (a_error) begin a_err_cnt++; a_err_cyc = cyc; end
    if (a_busy) a_busy_cnt++;
    if (b_rd_en) b_addrs.push_back(b_addr);
    if (b_valid && b_ready) begin
      b_words.push_back(b_data);
      if (b_last) begin b_last_cnt++; b_last_pos = b_words.size(); b_last_cyc = cyc; end
    end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    if (b_error) b_err_cnt++;
    if (b_busy) b_busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clear();
    a_words.delete(); a_addrs.delete();
    a_done_cnt = 0; a_done_cyc = -1; a_err_cnt = 0; a_err_cyc = -1; a_busy_cnt = 0;
    a_first_valid = -1; a_last_pos = -1; a_last_cnt = 0; a_last_cyc = -1;
  endtask

  task automatic b_clear();
    b_words.delete(); b_addrs.delete();
    b_done_cnt = 0; b_done_cyc = -1; b_last_pos = -1; b_last_cnt = 0; b_last_cyc = -1;
    b_err_cnt = 0; b_busy_cnt = 0;
  endtask

  // Expected A word k for start_ptr 5: both halves of sample at address (5 + k/2) % 8
  function automatic logic [15:0] a_exp_word(input int k);
    return 16'((5 + k / 2) % 8);
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    got = {a_busy, a_valid, a_rd_en, a_last, a_done, a_error, |a_addr, |a_data};
    n_cmp++; if (got !== 8'h00) begin n_bad++; $display("FAIL reset_a_outputs: got %b expected 00000000", got); end
    got = {b_busy, b_valid, b_rd_en, b_last, b_done, b_error, |b_addr, |b_data};
    n_cmp++; if (got !== 8'h00) begin n_bad++; $display("FAIL reset_b_outputs: got %b expected 00000000", got); end
    // start held high across reset release must not launch a readout
    @(posedge clk); #1; rst = 1'b0;
    a_clear(); b_clear();
    repeat (6) tick();
    n_cmp++; if (a_busy_cnt !== 0 || a_err_cnt !== 0 || a_addrs.size() !== 0) begin
      n_bad++; $display("FAIL reset_start_held_a: busy_cycles %0d errors %0d reads %0d expected 0 0 0", a_busy_cnt, a_err_cnt, a_addrs.size());
    end
    n_cmp++; if (b_busy_cnt !== 0 || b_err_cnt !== 0) begin
      n_bad++; $display("FAIL reset_start_held_b: busy_cycles %0d errors %0d expected 0 0", b_busy_cnt, b_err_cnt);
    end
    a_start = 0; b_start = 0;
    tick();
  endtask

  task automatic run_a_full(input string tag, input int n0);
    for (int k = 0; k < 200 && a_done_cnt == 0; k++) tick();
    n_cmp++; if (a_done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d expected 1", tag, a_done_cnt); end
    n_cmp++; if (a_addrs.size() !== 8) begin n_bad++; $display("FAIL %s_read_count: got %0d expected 8", tag, a_addrs.size()); end
    for (int i = 0; i < 8 && i < a_addrs.size(); i++) begin
      n_cmp++; if (a_addrs[i] !== 3'((5 + i) % 8)) begin n_bad++; $display("FAIL %s_addr[%0d]: got %0d expected %0d", tag, i, a_addrs[i], (5 + i) % 8); end
    end
    n_cmp++; if (a_words.size() !== 16) begin n_bad++; $display("FAIL %s_word_count: got %0d expected 16", tag, a_words.size()); end
    for (int k = 0; k < 16 && k < a_words.size(); k++) begin
      n_cmp++; if (a_words[k] !== a_exp_word(k)) begin n_bad++; $display("FAIL %s_word[%0d]: got %h expected %h", tag, k, a_words[k], a_exp_word(k)); end
    end
    n_cmp++; if (a_last_cnt !== 1 || a_last_pos !== 16) begin n_bad++; $display("FAIL %s_last: count %0d at word %0d expected 1 at word 16", tag, a_last_cnt, a_last_pos); end
    n_cmp++; if (a_done_cyc !== a_last_cyc + 1) begin n_bad++; $display("FAIL %s_done_after_last: done cyc %0d last cyc %0d expected last+1", tag, a_done_cyc, a_last_cyc); end
    if (n0 >= 0) begin
      n_cmp++; if (a_first_valid !== n0 + 4) begin n_bad++; $display("FAIL %s_first_valid_cyc: got %0d expected %0d", tag, a_first_valid, n0 + 4); end
      n_cmp++; if (a_done_cyc !== n0 + 41) begin n_bad++; $display("FAIL %s_done_cyc: got %0d expected %0d", tag, a_done_cyc, n0 + 41); end
    end
  endtask

  task automatic test_readout();
    int n0;
    a_clear(); a_ptr = 3'd5; a_la = 4'd4; a_ready = 1;
    tick(); n0 = cyc; a_start = 1; tick(); a_start = 0;
    n_cmp++; if (a_rd_en !== 1'b1 || a_addr !== 3'd5) begin n_bad++; $display("FAIL readout_first_fetch: rd_en %b addr %0d expected 1 5", a_rd_en, a_addr); end
    repeat (8) tick();
    a_start = 1; tick(); a_start = 0;  // ignored while busy
    run_a_full("readout", n0);
    n_cmp++; if (a_err_cnt !== 0) begin n_bad++; $display("FAIL readout_busy_start_error: got %0d expected 0", a_err_cnt); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL readout_busy_after_done: got %b expected 0", a_busy); end
  endtask

  task automatic test_nonpow2_narrow();
    int n0;
    logic [15:0] lo;
    b_mem[3] = 20'hABCDE;
    b_clear(); b_ptr = 3'd4; b_ready = 1;
    tick(); n0 = cyc; b_start = 1; tick(); b_start = 0;
    for (int k = 0; k < 200 && b_done_cnt == 0; k++) tick();
    n_cmp++; if (b_addrs.size() !== 6) begin n_bad++; $display("FAIL np2_read_count: got %0d expected 6", b_addrs.size()); end
    for (int i = 0; i < 6 && i < b_addrs.size(); i++) begin
      n_cmp++; if (b_addrs[i] !== 3'((4 + i) % 6)) begin n_bad++; $display("FAIL np2_addr[%0d]: got %0d expected %0d", i, b_addrs[i], (4 + i) % 6); end
    end
    n_cmp++; if (b_words.size() !== 12) begin n_bad++; $display("FAIL np2_word_count: got %0d expected 12", b_words.size()); end
    for (int j = 0; j < 6 && 2 * j + 1 < b_words.size(); j++) begin
      lo = ((4 + j) % 6 == 3) ? 16'hBCDE : 16'hBCD0 + 16'((4 + j) % 6);
      n_cmp++; if (b_words[2*j] !== lo) begin n_bad++; $display("FAIL np2_low[%0d]: got %h expected %h", j, b_words[2*j], lo); end
      n_cmp++; if (b_words[2*j+1] !== 16'h000A) begin n_bad++; $display("FAIL np2_high[%0d]: got %h expected 000a", j, b_words[2*j+1]); end
    end
    n_cmp++; if (b_last_cnt !== 1 || b_last_pos !== 12) begin n_bad++; $display("FAIL np2_last: count %0d at word %0d expected 1 at word 12", b_last_cnt, b_last_pos); end
    n_cmp++; if (b_done_cnt !== 1 || b_done_cyc !== n0 + 31) begin n_bad++; $display("FAIL np2_done: count %0d cyc %0d expected 1 at %0d", b_done_cnt, b_done_cyc, n0 + 31); end
  endtask

  task automatic test_backpressure();
    logic        stalled;
    logic [15:0] held;
    int          lows;
    stalled = 0; held = '0; lows = 0;
    a_clear(); a_ready = 1;
    tick(); a_start = 1; tick(); a_start = 0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (a_done_cnt != 0) break;
      if (lows >= 4) a_ready = 1;
      else a_ready = 1'($urandom_range(0, 1));
      lows = a_ready ? 0 : lows + 1;
      @(negedge clk);
      if (stalled) begin
        n_cmp++; if (a_valid !== 1'b1 || a_data !== held) begin
          n_bad++; $display("FAIL bp_hold: valid %b data %h expected 1 %h", a_valid, a_data, held);
        end
      end
      stalled = a_valid & ~a_ready;
      held    = a_data;
    end
    a_ready = 1;
    run_a_full("bp", -1);
  endtask

  task automatic test_bad_state();
    int n0;
    a_clear(); a_la = 4'd2;
    tick(); n0 = cyc; a_start = 1; tick(); a_start = 0;
    repeat (5) tick();
    n_cmp++; if (a_err_cnt !== 1 || a_err_cyc !== n0 + 1) begin n_bad++; $display("FAIL bad_state_error: count %0d cyc %0d expected 1 at %0d", a_err_cnt, a_err_cyc, n0 + 1); end
    n_cmp++; if (a_busy_cnt !== 0 || a_addrs.size() !== 0 || a_done_cnt !== 0) begin
      n_bad++; $display("FAIL bad_state_idle: busy %0d reads %0d done %0d expected 0 0 0", a_busy_cnt, a_addrs.size(), a_done_cnt);
    end
    // abort beats a simultaneous valid start
    a_clear(); a_la = 4'd4; a_abort = 1; a_start = 1; tick(); a_abort = 0; a_start = 0;
    repeat (3) tick();
    n_cmp++; if (a_busy_cnt !== 0 || a_err_cnt !== 0) begin n_bad++; $display("FAIL abort_vs_start: busy %0d errors %0d expected 0 0", a_busy_cnt, a_err_cnt); end
  endtask

  task automatic test_abort();
    a_clear(); a_ready = 1;
    tick(); a_start = 1; tick(); a_start = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (a_words.size() >= 6) a_ready = 0;
      if (a_words.size() >= 6 && a_valid) break;
    end
    a_abort = 1; tick(); a_abort = 0;
    n_cmp++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL abort_next_cycle: valid %b busy %b expected 0 0", a_valid, a_busy); end
    repeat (5) tick();
    n_cmp++; if (a_done_cnt !== 0 || a_words.size() !== 6 || a_err_cnt !== 0) begin
      n_bad++; $display("FAIL abort_quiet: done %0d words %0d errors %0d expected 0 6 0", a_done_cnt, a_words.size(), a_err_cnt);
    end
    a_clear(); a_ready = 1;
    tick(); a_start = 1; tick(); a_start = 0;
    run_a_full("replay", -1);
  endtask

`ifdef LA_READOUT_TIMEOUT_EN
  task automatic test_timeout();
    int n0;
    a_clear(); a_ready = 0;
    tick(); n0 = cyc; a_start = 1; tick(); a_start = 0;
    repeat (20) tick();
    n_cmp++; if (a_err_cnt !== 1 || a_err_cyc !== n0 + 14) begin n_bad++; $display("FAIL timeout_error: count %0d cyc %0d expected 1 at %0d", a_err_cnt, a_err_cyc, n0 + 14); end
    n_cmp++; if (a_done_cnt !== 0 || a_busy !== 1'b0 || a_words.size() !== 0) begin
      n_bad++; $display("FAIL timeout_idle: done %0d busy %b words %0d expected 0 0 0", a_done_cnt, a_busy, a_words.size());
    end
    a_ready = 1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) a_mem[i] = 32'(i) * 32'h0001_0001;
    for (int i = 0; i < 6; i++) b_mem[i] = 20'hABCD0 + 20'(i);
    a_start = 1; b_start = 1;
    a_clear(); b_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_readout();
    test_nonpow2_narrow();
    test_backpressure();
    test_bad_state();
    test_abort();
`ifdef LA_READOUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
